// File: rtl/regfile_wb_drive_pkg.sv
// Shared definitions for the register-file write side and the gazump comparators.
package regfile_wb_drive_pkg;

    // Default geometry; the gazump comparator width tracks RF_NPORT.
    localparam int RF_NSRC   = 12;
    localparam int RF_NPORT  = 10;
    localparam int RF_ADDR_W = 7;
    localparam int RF_DATA_W = 32;

    // One registered write port as seen by the array and the read-side comparators.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
        logic                 wen;
    } wr_port_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_rr_select.sv
// Rotating-priority selector: walks sources from ptr, takes the first NPORT
// valid sources with distinct addresses and assigns them to ports in scan order.
// Purely combinational.
module regfile_wb_rr_select
    import regfile_wb_drive_pkg::*;
#(
    parameter int NSRC       = RF_NSRC,
    parameter int NPORT      = RF_NPORT,
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int IDX_W      = idx_w(RF_NSRC)
) (
    input  logic [IDX_W-1:0]                 ptr_i,
    input  logic [NSRC-1:0]                  src_valid_i,
    input  logic [NSRC*ADDR_WIDTH-1:0]       src_addr_i,
    output logic [NSRC-1:0]                  grant_o,
    output logic [NPORT-1:0]                 port_vld_o,
    output logic [NPORT-1:0][IDX_W-1:0]      port_idx_o,
    output logic                             miss_vld_o,
    output logic [IDX_W-1:0]                 miss_idx_o
);

    logic [NSRC-1:0]                  rot_vld;
    logic [NSRC-1:0][ADDR_WIDTH-1:0]  rot_addr;
    logic [NSRC-1:0][IDX_W-1:0]       rot_idx;
    logic [NSRC-1:0]                  rot_grant;
    logic [NPORT-1:0][ADDR_WIDTH-1:0] taken_addr;
    int                               taken;
    logic                             hit;

    // Rotate sources into scan order: slot j holds source (ptr+j) mod NSRC.
    always_comb begin
        rot_vld  = '0;
        rot_addr = '0;
        rot_idx  = '0;
        for (int j = 0; j < NSRC; j++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (s == (int'(ptr_i) + j) % NSRC) begin
                    rot_vld[j]  = src_valid_i[s];
                    rot_addr[j] = src_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH];
                    rot_idx[j]  = IDX_W'(s);
                end
            end
        end
    end

    // Walk scan order; a source already matching a taken address is skipped
    // without consuming a port, and the first skipped source becomes the next ptr.
    always_comb begin
        rot_grant  = '0;
        port_vld_o = '0;
        port_idx_o = '0;
        taken_addr = '0;
        taken      = 0;
        hit        = 1'b0;
        miss_vld_o = 1'b0;
        miss_idx_o = '0;
        for (int j = 0; j < NSRC; j++) begin
            if (rot_vld[j]) begin
                hit = 1'b0;
                for (int m = 0; m < NPORT; m++) begin
                    if (m < taken && taken_addr[m] == rot_addr[j]) begin
                        hit = 1'b1;
                    end
                end
                if (taken < NPORT && !hit) begin
                    for (int m = 0; m < NPORT; m++) begin
                        if (m == taken) begin
                            taken_addr[m] = rot_addr[j];
                            port_idx_o[m] = rot_idx[j];
                            port_vld_o[m] = 1'b1;
                        end
                    end
                    rot_grant[j] = 1'b1;
                    taken        = taken + 1;
                end else if (!miss_vld_o) begin
                    miss_vld_o = 1'b1;
                    miss_idx_o = rot_idx[j];
                end
            end
        end
    end

    // Map scan-order grants back to source positions.
    always_comb begin
        grant_o = '0;
        for (int j = 0; j < NSRC; j++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (rot_idx[j] == IDX_W'(s)) begin
                    grant_o[s] = rot_grant[j];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_drive.sv
// Register-file write driver: grants up to NPORT results per cycle and presents
// them on registered write ports shared by the array and the gazump comparators.
module regfile_wb_drive
    import regfile_wb_drive_pkg::*;
#(
    parameter int NSRC       = RF_NSRC,
    parameter int NPORT      = RF_NPORT,
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NSRC-1:0]               src_valid,
    input  logic [NSRC*ADDR_WIDTH-1:0]    src_addr,
    input  logic [NSRC*DATA_WIDTH-1:0]    src_data,
    output logic [NSRC-1:0]               src_ready,
    input  logic                          write_stall,
    input  logic                          flush,
    output logic [NPORT*ADDR_WIDTH-1:0]   write_addr_reg,
    output logic [NPORT-1:0]              write_wen_reg,
    output logic [NPORT*DATA_WIDTH-1:0]   write_data_reg,
    output logic                          err_dup
);

    localparam int IDX_W = idx_w(NSRC);

    logic [IDX_W-1:0]              ptr_q,  ptr_d;
    logic [NPORT-1:0]              wen_q,  wen_d;
    logic [NPORT*ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NPORT*DATA_WIDTH-1:0]   data_q, data_d;
    logic                          err_q,  err_d;

    logic [NSRC-1:0]               sel_grant;
    logic [NPORT-1:0]              sel_port_vld;
    logic [NPORT-1:0][IDX_W-1:0]   sel_port_idx;
    logic                          sel_miss_vld;
    logic [IDX_W-1:0]              sel_miss_idx;
    logic                          blk;
    logic                          dup_any;

    regfile_wb_rr_select #(
        .NSRC       (NSRC),
        .NPORT      (NPORT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W)
    ) u_sel (
        .ptr_i       (ptr_q),
        .src_valid_i (src_valid),
        .src_addr_i  (src_addr),
        .grant_o     (sel_grant),
        .port_vld_o  (sel_port_vld),
        .port_idx_o  (sel_port_idx),
        .miss_vld_o  (sel_miss_vld),
        .miss_idx_o  (sel_miss_idx)
    );

    assign blk       = write_stall | flush;
    assign src_ready = (rst || blk) ? '0 : sel_grant;

    // Diagnostic: any two valid sources targeting the same register this cycle.
    always_comb begin
        dup_any = 1'b0;
        for (int a = 0; a < NSRC; a++) begin
            for (int b = a + 1; b < NSRC; b++) begin
                if (src_valid[a] && src_valid[b] &&
                    src_addr[a*ADDR_WIDTH +: ADDR_WIDTH] == src_addr[b*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    dup_any = 1'b1;
                end
            end
        end
    end

    // Next port contents and pointer; flush beats stall, stall freezes everything.
    always_comb begin
        ptr_d  = ptr_q;
        wen_d  = wen_q;
        addr_d = addr_q;
        data_d = data_q;
        err_d  = err_q;
        if (flush) begin
            wen_d = '0;
            ptr_d = '0;
        end else if (!write_stall) begin
            for (int k = 0; k < NPORT; k++) begin
                wen_d[k] = sel_port_vld[k];
                if (sel_port_vld[k]) begin
                    for (int s = 0; s < NSRC; s++) begin
                        if (sel_port_idx[k] == IDX_W'(s)) begin
                            addr_d[k*ADDR_WIDTH +: ADDR_WIDTH] = src_addr[s*ADDR_WIDTH +: ADDR_WIDTH];
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = src_data[s*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
            if (sel_miss_vld) begin
                ptr_d = sel_miss_idx;
            end
            err_d = err_q | dup_any;
        end
    end

    // Port, pointer and sticky error registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            wen_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign write_addr_reg = addr_q;
    assign write_wen_reg  = wen_q;
    assign write_data_reg = data_q;
    assign err_dup        = err_q;

endmodule
